ddr_pattern_tester: RTL and testbench

DDR_PATTERN_TESTER -- requirements
Module: ddr_pattern_tester

---
 rtl/ddr_pattern_tester.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ddr_pattern_tester.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_pattern_tester.sv
// ddr_pattern_tester
// Writes NUM_WORDS pattern words into one bank of a DDR controller, reads them
// back, compares against the regenerated pattern and reports errors.
//
// Handshake: a command (CMD_WRITE / CMD_READ) is a single-cycle pulse and
// is only issued in a cycle where CTRL_BUSY was sampled low. RD_VALID is a
// one-cycle strobe qualifying RD_DATA and is only consumed in RD_WAIT.
//
// Ports:
//   SYS_CLK_100M  sole clock, rising edge
//   RESET         asynchronous active-high reset
//   START         run request, sampled only in IDLE
//   MODE          pattern: 00 incr, 01 walking-one, 10 LFSR, 11 checkerboard
//   BASE_BA       bank under test
//   BASE_ROW      first row under test
//   CMD_WRITE     one-cycle write command
//   CMD_READ      one-cycle read command
//   CMD_BA/ROW/COL command address
//   WR_DATA       write data, valid with CMD_WRITE
//   CTRL_BUSY     controller busy
//   RD_DATA       read data
//   RD_VALID      read data strobe
//   BUSY          run in progress
//   DONE          run complete, held until next START
//   PASS          DONE with zero errors
//   ERR_COUNT     mismatches + timeouts, saturating
//   FIRST_ERR_IDX word index of first error
//   LED           {DONE, PASS, BUSY, ERR_COUNT[4:0]}
//   DBG_STATE     current FSM state encoding
module ddr_pattern_tester #(
  parameter int DATA_W    = 16,
  parameter int ROW_W     = 13,
  parameter int COL_W     = 10,
  parameter int BA_W      = 2,
  parameter int NUM_WORDS = 256,
  parameter int TIMEOUT   = 1023
) (
  input  logic                   SYS_CLK_100M,
  input  logic                   RESET,
  input  logic                   START,
  input  logic [1:0]             MODE,
  input  logic [BA_W-1:0]        BASE_BA,
  input  logic [ROW_W-1:0]       BASE_ROW,
  output logic                   CMD_WRITE,
  output logic                   CMD_READ,
  output logic [BA_W-1:0]        CMD_BA,
  output logic [ROW_W-1:0]       CMD_ROW,
  output logic [COL_W-1:0]       CMD_COL,
  output logic [DATA_W-1:0]      WR_DATA,
  input  logic                   CTRL_BUSY,
  input  logic [DATA_W-1:0]      RD_DATA,
  input  logic                   RD_VALID,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   PASS,
  output logic [15:0]            ERR_COUNT,
  output logic [ROW_W+COL_W-1:0] FIRST_ERR_IDX,
  output logic [7:0]             LED,
  output logic [2:0]             DBG_STATE
);

  localparam int IDX_W = ROW_W + COL_W;
  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0]     LAST_IDX   = (IDX_W+1)'(NUM_WORDS - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
  localparam logic [31:0]        LFSR_POLY  = 32'h80200003;
  localparam logic [31:0]        LFSR_SEED  = 32'h00000001;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_FINISH   = 3'd5
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [31:0]         r_lfsr;
  logic [1:0]          r_mode;
  logic [BA_W-1:0]     r_ba;
  logic [ROW_W-1:0]    r_row;
  logic [15:0]         r_err;
  logic [IDX_W-1:0]    r_first;
  logic                r_done;
  logic                r_pass;
  logic                r_busy;
  logic                r_cmd_wr;
  logic                r_cmd_rd;
  logic [BA_W-1:0]     r_cmd_ba;
  logic [ROW_W-1:0]    r_cmd_row;
  logic [COL_W-1:0]    r_cmd_col;
  logic [DATA_W-1:0]   r_wr_data;
  logic                r_first_wait;
  logic [TMO_W-1:0]    r_tmo;

  logic                w_last;
  logic [31:0]         w_lfsr_next;
  logic [IDX_W-1:0]    w_walk_sh;
  logic [DATA_W-1:0]   w_walk;
  logic [DATA_W-1:0]   w_checker;
  logic [DATA_W-1:0]   w_pattern;
  logic [ROW_W-1:0]    w_row;
  logic [COL_W-1:0]    w_col;
  logic [15:0]         w_err_inc;
  logic                w_rd_done;
  logic                w_rd_bad;

  assign w_last      = ({1'b0, r_idx} == LAST_IDX);
  // Right-shifting Galois LFSR: feedback taps applied when the bit shifted out is 1.
  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_POLY : 32'h0);
  assign w_walk_sh   = r_idx % IDX_W'(DATA_W);
  assign w_walk      = DATA_W'(1) << w_walk_sh;
  // Row wraps modulo 2^ROW_W through the truncating add.
  assign w_row       = r_row + ROW_W'(r_idx >> COL_W);
  assign w_col       = r_idx[COL_W-1:0];
  assign w_err_inc   = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
  // A read slot ends on data or on the last timeout cycle; no data is an error.
  assign w_rd_done   = RD_VALID || (r_tmo == TMO_LAST);
  assign w_rd_bad    = !RD_VALID || (RD_DATA != w_pattern);

  always_comb begin
    w_checker = '0;
    // Even words: ...1010, odd words: ...0101.
    for (int k = 0; k < DATA_W; k++) begin
      w_checker[k] = k[0] ^ r_idx[0];
    end
  end

  always_comb begin
    w_pattern = '0;
    case (r_mode)
      2'b00:   w_pattern = DATA_W'(r_idx);
      2'b01:   w_pattern = w_walk;
      2'b10:   w_pattern = r_lfsr[DATA_W-1:0];
      default: w_pattern = w_checker;
    endcase
  end

  always_ff @(posedge SYS_CLK_100M or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_lfsr       <= LFSR_SEED;
      r_mode       <= '0;
      r_ba         <= '0;
      r_row        <= '0;
      r_err        <= '0;
      r_first      <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_busy       <= 1'b0;
      r_cmd_wr     <= 1'b0;
      r_cmd_rd     <= 1'b0;
      r_cmd_ba     <= '0;
      r_cmd_row    <= '0;
      r_cmd_col    <= '0;
      r_wr_data    <= '0;
      r_first_wait <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_cmd_wr <= 1'b0;
      r_cmd_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_mode  <= MODE;
            r_ba    <= BASE_BA;
            r_row   <= BASE_ROW;
            r_err   <= '0;
            r_first <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_idx   <= '0;
            r_lfsr  <= LFSR_SEED;
            r_busy  <= 1'b1;
            r_state <= S_WR_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          if (!CTRL_BUSY) begin
            r_cmd_wr     <= 1'b1;
            r_cmd_ba     <= r_ba;
            r_cmd_row    <= w_row;
            r_cmd_col    <= w_col;
            r_wr_data    <= w_pattern;
            r_first_wait <= 1'b1;
            r_state      <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          // The controller may not have raised BUSY yet in the cycle right
          // after the command, so that cycle is skipped.
          if (r_first_wait) begin
            r_first_wait <= 1'b0;
          end else if (!CTRL_BUSY) begin
            if (w_last) begin
              r_idx   <= '0;
              r_lfsr  <= LFSR_SEED;
              r_state <= S_RD_ISSUE;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_lfsr  <= w_lfsr_next;
              r_state <= S_WR_ISSUE;
            end
          end
        end
        S_RD_ISSUE: begin
          if (!CTRL_BUSY) begin
            r_cmd_rd  <= 1'b1;
            r_cmd_ba  <= r_ba;
            r_cmd_row <= w_row;
            r_cmd_col <= w_col;
            r_tmo     <= '0;
            r_state   <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          if (w_rd_done) begin
            if (w_rd_bad) begin
              r_err <= w_err_inc;
              if (r_err == 16'd0) begin
                r_first <= r_idx;
              end
            end
            if (w_last) begin
              r_state <= S_FINISH;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_lfsr  <= w_lfsr_next;
              r_state <= S_RD_ISSUE;
            end
          end else begin
            r_tmo <= r_tmo + TMO_W'(1);
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_pass  <= (r_err == 16'd0);
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign CMD_WRITE     = r_cmd_wr;
  assign CMD_READ      = r_cmd_rd;
  assign CMD_BA        = r_cmd_ba;
  assign CMD_ROW       = r_cmd_row;
  assign CMD_COL       = r_cmd_col;
  assign WR_DATA       = r_wr_data;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign PASS          = r_pass;
  assign ERR_COUNT     = r_err;
  assign FIRST_ERR_IDX = r_first;
  assign LED           = {r_done, r_pass, r_busy, r_err[4:0]};
  assign DBG_STATE     = r_state;

endmodule

// File: tb/tb_ddr_pattern_tester.sv
// Bench for ddr_pattern_tester. Three instances share the clock:
//   a: NUM_WORDS=4 with an echoing controller model (main function, errors,
//      busy/START handling, reset mid-run)
//   b: NUM_WORDS=1030 (row step at word 1024)
//   c: NUM_WORDS=2, TIMEOUT=15 with no read responses (timeouts)
module tb_ddr_pattern_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared run configuration inputs
  logic [1:0]  mode     = 2'b00;
  logic [1:0]  base_ba  = 2'd0;
  logic [12:0] base_row = 13'd0;
  logic        tie_zero = 1'b0;
  logic [15:0] tie_data = 16'h0000;

  // Instance a
  logic a_rst = 1'b1, a_start = 1'b0, a_ctrl_busy = 1'b0;
  logic [15:0] a_rd_data;
  logic a_rd_valid;
  logic a_cmd_write, a_cmd_read, a_busy, a_done, a_pass;
  logic [1:0] a_cmd_ba;
  logic [12:0] a_cmd_row;
  logic [9:0] a_cmd_col;
  logic [15:0] a_wr_data, a_err;
  logic [22:0] a_first;
  logic [7:0] a_led;
  logic [2:0] a_dbg;

  ddr_pattern_tester #(.NUM_WORDS(4), .TIMEOUT(15)) dut_a (
    .SYS_CLK_100M(clk), .RESET(a_rst), .START(a_start), .MODE(mode),
    .BASE_BA(base_ba), .BASE_ROW(base_row), .CMD_WRITE(a_cmd_write),
    .CMD_READ(a_cmd_read), .CMD_BA(a_cmd_ba), .CMD_ROW(a_cmd_row),
    .CMD_COL(a_cmd_col), .WR_DATA(a_wr_data), .CTRL_BUSY(a_ctrl_busy),
    .RD_DATA(a_rd_data), .RD_VALID(a_rd_valid), .BUSY(a_busy), .DONE(a_done),
    .PASS(a_pass), .ERR_COUNT(a_err), .FIRST_ERR_IDX(a_first), .LED(a_led),
    .DBG_STATE(a_dbg)
  );

  // Instance b
  logic b_rst = 1'b1, b_start = 1'b0;
  logic b_cmd_write, b_cmd_read, b_busy, b_done, b_pass;
  logic [1:0] b_cmd_ba;
  logic [12:0] b_cmd_row;
  logic [9:0] b_cmd_col;
  logic [15:0] b_wr_data, b_err;
  logic [22:0] b_first;
  logic [7:0] b_led;
  logic [2:0] b_dbg;

  ddr_pattern_tester #(.NUM_WORDS(1030), .TIMEOUT(15)) dut_b (
    .SYS_CLK_100M(clk), .RESET(b_rst), .START(b_start), .MODE(mode),
    .BASE_BA(base_ba), .BASE_ROW(base_row), .CMD_WRITE(b_cmd_write),
    .CMD_READ(b_cmd_read), .CMD_BA(b_cmd_ba), .CMD_ROW(b_cmd_row),
    .CMD_COL(b_cmd_col), .WR_DATA(b_wr_data), .CTRL_BUSY(tie_zero),
    .RD_DATA(tie_data), .RD_VALID(tie_zero), .BUSY(b_busy), .DONE(b_done),
    .PASS(b_pass), .ERR_COUNT(b_err), .FIRST_ERR_IDX(b_first), .LED(b_led),
    .DBG_STATE(b_dbg)
  );

  // Instance c
  logic c_rst = 1'b1, c_start = 1'b0;
  logic c_cmd_write, c_cmd_read, c_busy, c_done, c_pass;
  logic [1:0] c_cmd_ba;
  logic [12:0] c_cmd_row;
  logic [9:0] c_cmd_col;
  logic [15:0] c_wr_data, c_err;
  logic [22:0] c_first;
  logic [7:0] c_led;
  logic [2:0] c_dbg;

  ddr_pattern_tester #(.NUM_WORDS(2), .TIMEOUT(15)) dut_c (
    .SYS_CLK_100M(clk), .RESET(c_rst), .START(c_start), .MODE(mode),
    .BASE_BA(base_ba), .BASE_ROW(base_row), .CMD_WRITE(c_cmd_write),
    .CMD_READ(c_cmd_read), .CMD_BA(c_cmd_ba), .CMD_ROW(c_cmd_row),
    .CMD_COL(c_cmd_col), .WR_DATA(c_wr_data), .CTRL_BUSY(tie_zero),
    .RD_DATA(tie_data), .RD_VALID(tie_zero), .BUSY(c_busy), .DONE(c_done),
    .PASS(c_pass), .ERR_COUNT(c_err), .FIRST_ERR_IDX(c_first), .LED(c_led),
    .DBG_STATE(c_dbg)
  );

  // Controller model + monitor for instance a (echo memory, optional
  // corruption of one column, optional stray RD_VALID after writes).
  int          m_corrupt = -1;
  logic        m_respond = 1'b1;
  logic        m_spur    = 1'b0;
  logic [15:0] mem [0:15];
  logic        rd_pend = 1'b0, spur_pend = 1'b0;
  logic [15:0] rd_pend_data = '0;
  int          a_wr_cnt = 0, a_rd_cnt = 0, a_both_cnt = 0;
  logic [15:0] obs_data [0:63];
  logic [9:0]  obs_col  [0:63];
  logic [12:0] obs_row  [0:63];
  logic [1:0]  obs_ba   [0:63];

  initial begin
    a_rd_valid = 1'b0;
    a_rd_data  = 16'h0000;
  end

  always @(negedge clk) begin
    a_rd_valid <= rd_pend || spur_pend;
    a_rd_data  <= rd_pend ? rd_pend_data : 16'hDEAD;
    spur_pend  <= a_cmd_write && m_spur;
    rd_pend    <= a_cmd_read && m_respond;
    if (a_cmd_write && a_cmd_read) a_both_cnt <= a_both_cnt + 1;
    if (a_cmd_write) begin
      mem[a_cmd_col[3:0]]      <= a_wr_data;
      obs_data[a_wr_cnt % 64]  <= a_wr_data;
      obs_col[a_wr_cnt % 64]   <= a_cmd_col;
      obs_row[a_wr_cnt % 64]   <= a_cmd_row;
      obs_ba[a_wr_cnt % 64]    <= a_cmd_ba;
      a_wr_cnt                 <= a_wr_cnt + 1;
    end
    if (a_cmd_read) begin
      rd_pend_data <= mem[a_cmd_col[3:0]] ^
                      ((int'(a_cmd_col) == m_corrupt) ? 16'h0100 : 16'h0000);
      a_rd_cnt     <= a_rd_cnt + 1;
    end
  end

  // Monitor for instance b
  int          b_wr_cnt = 0;
  logic [12:0] b_row_1023 = '0, b_row_1024 = '0;
  logic [9:0]  b_col_1023 = '0, b_col_1024 = '0;
  logic [1:0]  b_ba_1024 = '0;
  logic [15:0] b_data_1024 = '0;
  always @(negedge clk) begin
    if (b_cmd_write) begin
      if (b_wr_cnt == 1023) begin
        b_row_1023 <= b_cmd_row;
        b_col_1023 <= b_cmd_col;
      end
      if (b_wr_cnt == 1024) begin
        b_row_1024  <= b_cmd_row;
        b_col_1024  <= b_cmd_col;
        b_ba_1024   <= b_cmd_ba;
        b_data_1024 <= b_wr_data;
      end
      b_wr_cnt <= b_wr_cnt + 1;
    end
  end

  // Monitor for instance c
  int   c_rd_cnt = 0, c_done_cyc = 0;
  int   c_rd_cyc [0:7];
  logic c_done_q = 1'b0;
  always @(negedge clk) begin
    if (c_cmd_read) begin
      c_rd_cyc[c_rd_cnt % 8] <= cyc;
      c_rd_cnt               <= c_rd_cnt + 1;
    end
    if (c_done && !c_done_q) c_done_cyc <= cyc;
    c_done_q <= c_done;
  end

  logic [15:0] exp_q [$];

  // ---------------- driver tasks ----------------
  task automatic start_run(input int which, input logic [1:0] m,
                           input logic [1:0] ba, input logic [12:0] row);
    @(negedge clk);
    mode = m; base_ba = ba; base_row = row;
    case (which)
      0: a_start = 1'b1;
      1: b_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    @(negedge clk);
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 0 && a_done) || (which == 2 && c_done)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs instance a in one mode and checks written data against exp_q.
  task automatic run_a_and_check_writes(input string name, input logic [1:0] m);
    int wb;
    bit ok;
    logic [15:0] e;
    wb = a_wr_cnt;
    start_run(0, m, 2'd1, 13'd100);
    checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL %s_start busy=%b done=%b exp busy=1 done=0", name, a_busy, a_done);
    end
    wait_done(0, 200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_done_timeout done=%b exp=1", name, a_done);
    end
    checks++;
    if (a_wr_cnt - wb !== 4) begin
      failures++;
      $display("FAIL %s_wr_count got=%0d exp=4", name, a_wr_cnt - wb);
    end
    for (int j = 0; j < 4; j++) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_data[(wb + j) % 64] !== e || obs_col[(wb + j) % 64] !== 10'(j) ||
          obs_row[(wb + j) % 64] !== 13'd100 || obs_ba[(wb + j) % 64] !== 2'd1) begin
        failures++;
        $display("FAIL %s_write%0d got data=%h col=%0d row=%0d ba=%0d exp data=%h col=%0d row=100 ba=1",
                 name, j, obs_data[(wb + j) % 64], obs_col[(wb + j) % 64],
                 obs_row[(wb + j) % 64], obs_ba[(wb + j) % 64], e, j);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_cmd_write, a_cmd_read, a_cmd_ba, a_cmd_row, a_cmd_col, a_wr_data} !== '0) begin
      failures++;
      $display("FAIL reset_cmd got wr=%b rd=%b ba=%h row=%h col=%h data=%h exp all 0",
               a_cmd_write, a_cmd_read, a_cmd_ba, a_cmd_row, a_cmd_col, a_wr_data);
    end
    checks++;
    if ({a_busy, a_done, a_pass} !== 3'b000 || a_err !== 16'd0 || a_first !== 23'd0) begin
      failures++;
      $display("FAIL reset_status got busy=%b done=%b pass=%b err=%0d first=%0d exp 0",
               a_busy, a_done, a_pass, a_err, a_first);
    end
    checks++;
    if (a_led !== 8'h00 || a_dbg !== 3'd0) begin
      failures++;
      $display("FAIL reset_led_state got led=%h state=%0d exp led=00 state=0", a_led, a_dbg);
    end
    a_rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_incrementing();
    int rb;
    rb = a_rd_cnt;
    exp_q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    run_a_and_check_writes("incr", 2'b00);
    checks++;
    if (a_rd_cnt - rb !== 4) begin
      failures++;
      $display("FAIL incr_rd_count got=%0d exp=4", a_rd_cnt - rb);
    end
    checks++;
    if (a_pass !== 1'b1 || a_err !== 16'd0 || a_busy !== 1'b0 || a_led !== 8'hC0) begin
      failures++;
      $display("FAIL incr_result got pass=%b err=%0d busy=%b led=%h exp pass=1 err=0 busy=0 led=c0",
               a_pass, a_err, a_busy, a_led);
    end
  endtask

  task automatic test_walking_corrupt();
    m_corrupt = 2;
    exp_q = '{16'h0001, 16'h0002, 16'h0004, 16'h0008};
    run_a_and_check_writes("walk", 2'b01);
    checks++;
    if (a_err !== 16'd1 || a_first !== 23'd2 || a_pass !== 1'b0 || a_done !== 1'b1) begin
      failures++;
      $display("FAIL walk_result got err=%0d first=%0d pass=%b done=%b exp err=1 first=2 pass=0 done=1",
               a_err, a_first, a_pass, a_done);
    end
    checks++;
    if (a_led !== 8'h81) begin
      failures++;
      $display("FAIL walk_led got=%h exp=81", a_led);
    end
    m_corrupt = -1;
  endtask

  task automatic test_lfsr_stray_valid();
    m_spur = 1'b1;
    exp_q = '{16'h0001, 16'h0003, 16'h0002, 16'h0001};
    run_a_and_check_writes("lfsr", 2'b10);
    checks++;
    if (a_err !== 16'd0 || a_pass !== 1'b1) begin
      failures++;
      $display("FAIL lfsr_result got err=%0d pass=%b exp err=0 pass=1", a_err, a_pass);
    end
    m_spur = 1'b0;
  endtask

  task automatic test_checkerboard();
    exp_q = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
    run_a_and_check_writes("checker", 2'b11);
    checks++;
    if (a_pass !== 1'b1 || a_both_cnt !== 0) begin
      failures++;
      $display("FAIL checker_result got pass=%b both_cmd=%0d exp pass=1 both_cmd=0", a_pass, a_both_cnt);
    end
  endtask

  task automatic test_busy_and_restart();
    int wb;
    bit ok;
    logic seen;
    wb = a_wr_cnt;
    seen = 1'b0;
    start_run(0, 2'b00, 2'd0, 13'd7);
    a_ctrl_busy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen = seen | a_cmd_write | a_cmd_read;
      if (k == 2) a_start = 1'b1;
      if (k == 3) a_start = 1'b0;
    end
    checks++;
    if (seen !== 1'b0 || a_dbg !== 3'd1) begin
      failures++;
      $display("FAIL busy_hold got cmd_seen=%b state=%0d exp cmd_seen=0 state=1", seen, a_dbg);
    end
    a_ctrl_busy = 1'b0;
    wait_done(0, 200, ok);
    repeat (20) @(negedge clk);
    checks++;
    if (!ok || a_wr_cnt - wb !== 4 || a_pass !== 1'b1 || a_busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_restart got done=%b writes=%0d pass=%b busy=%b exp done=1 writes=4 pass=1 busy=0",
               ok, a_wr_cnt - wb, a_pass, a_busy);
    end
    checks++;
    if (obs_data[wb % 64] !== 16'h0000 || obs_row[wb % 64] !== 13'd7) begin
      failures++;
      $display("FAIL busy_first_write got data=%h row=%0d exp data=0000 row=7",
               obs_data[wb % 64], obs_row[wb % 64]);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    c_rst = 1'b0;
    @(negedge clk);
    start_run(2, 2'b00, 2'd0, 13'd0);
    wait_done(2, 300, ok);
    @(negedge clk);
    checks++;
    if (!ok || c_err !== 16'd2 || c_first !== 23'd0 || c_pass !== 1'b0 || c_rd_cnt !== 2) begin
      failures++;
      $display("FAIL timeout_result got done=%b err=%0d first=%0d pass=%b reads=%0d exp done=1 err=2 first=0 pass=0 reads=2",
               ok, c_err, c_first, c_pass, c_rd_cnt);
    end
    checks++;
    if (c_rd_cyc[1] - c_rd_cyc[0] !== 16 || c_done_cyc - c_rd_cyc[1] !== 16) begin
      failures++;
      $display("FAIL timeout_spacing got read_gap=%0d done_gap=%0d exp 16 and 16",
               c_rd_cyc[1] - c_rd_cyc[0], c_done_cyc - c_rd_cyc[1]);
    end
  endtask

  task automatic test_row_rollover();
    bit ok;
    b_rst = 1'b0;
    @(negedge clk);
    start_run(1, 2'b00, 2'd3, 13'd5);
    ok = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (b_wr_cnt > 1025) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rollover_timeout got writes=%0d exp >1025", b_wr_cnt);
    end
    checks++;
    if (b_row_1023 !== 13'd5 || b_col_1023 !== 10'd1023) begin
      failures++;
      $display("FAIL rollover_1023 got row=%0d col=%0d exp row=5 col=1023", b_row_1023, b_col_1023);
    end
    checks++;
    if (b_row_1024 !== 13'd6 || b_col_1024 !== 10'd0 || b_ba_1024 !== 2'd3 || b_data_1024 !== 16'h0400) begin
      failures++;
      $display("FAIL rollover_1024 got row=%0d col=%0d ba=%0d data=%h exp row=6 col=0 ba=3 data=0400",
               b_row_1024, b_col_1024, b_ba_1024, b_data_1024);
    end
    #1 b_rst = 1'b1;
    #1;
    checks++;
    if (b_busy !== 1'b0 || b_cmd_write !== 1'b0 || b_dbg !== 3'd0) begin
      failures++;
      $display("FAIL rollover_reset got busy=%b wr=%b state=%0d exp 0 0 0", b_busy, b_cmd_write, b_dbg);
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int wb, rb;
    m_respond = 1'b0;
    start_run(0, 2'b00, 2'd0, 13'd0);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (a_cmd_read) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL midrst_no_read got cmd_read=%b exp=1", a_cmd_read);
    end
    #1 a_rst = 1'b1;
    #1;
    checks++;
    if (a_cmd_read !== 1'b0 || a_busy !== 1'b0 || a_dbg !== 3'd0 || a_led !== 8'h00) begin
      failures++;
      $display("FAIL midrst_async got rd=%b busy=%b state=%0d led=%h exp 0 0 0 00",
               a_cmd_read, a_busy, a_dbg, a_led);
    end
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    wb = a_wr_cnt;
    rb = a_rd_cnt;
    repeat (30) @(negedge clk);
    checks++;
    if (a_wr_cnt !== wb || a_rd_cnt !== rb || a_busy !== 1'b0 || a_done !== 1'b0) begin
      failures++;
      $display("FAIL midrst_quiet got new_wr=%0d new_rd=%0d busy=%b done=%b exp 0 0 0 0",
               a_wr_cnt - wb, a_rd_cnt - rb, a_busy, a_done);
    end
    m_respond = 1'b1;
  endtask

  initial begin
    test_reset();
    test_incrementing();
    test_walking_corrupt();
    test_lfsr_stray_valid();
    test_checkerboard();
    test_busy_and_restart();
    test_timeout();
    test_row_rollover();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
